// File: rtl/countdown_tick_gen.sv
// -----------------------------------------------------------------------------
// countdown_tick_gen
//
// Programmable clock-enable generator feeding the LED blink stage. The board
// clock is divided by a runtime-loadable half-period (active_div): a one-cycle
// tick is emitted every active_div running cycles and clk_slow toggles with
// each tick, giving a registered 50%-duty square wave of period 2*active_div.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   reset_n    in   synchronous reset, active-low
//   enable     in   level: 1 = count, 0 = pause/hold
//   clear      in   synchronous restart pulse (keeps active_div)
//   div_valid  in   new half-period offered
//   div_data   in   new half-period in cycles (0 is stored as 1)
//   div_ready  out  new half-period can be accepted (~pending & ~clear)
//   tick       out  one-cycle pulse per half-period (registered)
//   clk_slow   out  registered square wave, toggles with each tick
//   state      out  FSM state: 00 IDLE, 01 RUN, 10 PAUSE
//   tick_count out  (only with TICK_COUNT_EN) wrapping 16-bit tick counter
//
// Optional feature macro: TICK_COUNT_EN adds the tick_count output.
// -----------------------------------------------------------------------------
module countdown_tick_gen #(
    parameter int DIV_W       = 27,
    parameter int DEFAULT_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             div_valid,
    input  logic [DIV_W-1:0] div_data,
    output logic             div_ready,
    output logic             tick,
    output logic             clk_slow,
    output logic [1:0]       state
`ifdef TICK_COUNT_EN
    ,
    output logic [15:0]      tick_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

    // A zero half-period would never terminate; it is promoted to 1.
    function automatic logic [DIV_W-1:0] sanitize_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? ONE : d;
    endfunction

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             tick_q, tick_d;
    logic             slow_q, slow_d;
    logic             accept;
`ifdef TICK_COUNT_EN
    logic [15:0]      tc_q, tc_d;
`endif

    assign div_ready = ~pending_q & ~clear;
    assign accept    = div_valid & div_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        tick_d    = 1'b0;
        slow_d    = slow_q;

        if (clear) begin
            // Restart from the top of the current period; a queued divisor is dropped.
            state_d   = S_IDLE;
            cnt_d     = active_q - ONE;
            slow_d    = 1'b0;
            pending_d = 1'b0;
        end else begin
            // accept implies pending_q==0, so it never collides with an apply below.
            if (accept) begin
                shadow_d  = sanitize_div(div_data);
                pending_d = 1'b1;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (pending_q) begin
                        // Nothing is being timed yet, so apply the new divisor at once.
                        active_d  = shadow_q;
                        cnt_d     = shadow_q - ONE;
                        pending_d = 1'b0;
                    end else begin
                        cnt_d = active_q - ONE;
                    end
                    if (enable) state_d = S_RUN;
                end
                S_RUN: begin
                    if (cnt_q == '0) begin
                        tick_d = 1'b1;
                        slow_d = ~slow_q;
                        // Divisor swaps only at a period boundary to keep clk_slow glitch-free.
                        if (pending_q) begin
                            active_d  = shadow_q;
                            cnt_d     = shadow_q - ONE;
                            pending_d = 1'b0;
                        end else begin
                            cnt_d = active_q - ONE;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                    // The counting action above still happens on the edge that pauses.
                    if (!enable) state_d = S_PAUSE;
                end
                S_PAUSE: begin
                    if (enable) state_d = S_RUN;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

`ifdef TICK_COUNT_EN
    always_comb begin
        tc_d = tc_q;
        if (clear)       tc_d = '0;
        else if (tick_d) tc_d = tc_q + 16'd1;
    end
`endif

    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
        if (!reset_n) begin
            state_q   <= S_IDLE;
            active_q  <= DEF_DIV;
            cnt_q     <= DEF_DIV - ONE;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
            slow_q    <= 1'b0;
`ifdef TICK_COUNT_EN
            tc_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            slow_q    <= slow_d;
`ifdef TICK_COUNT_EN
            tc_q      <= tc_d;
`endif
        end
    end

    assign tick     = tick_q;
    assign clk_slow = slow_q;
    assign state    = state_q;
`ifdef TICK_COUNT_EN
    assign tick_count = tc_q;
`endif

endmodule

// File: tb/tb_countdown_tick_gen.sv
module tb_countdown_tick_gen;

    localparam int DIV_W = 8;
    localparam int DEF   = 4;

    logic             clk = 1'b0;
    logic             reset_n, enable, clear, div_valid;
    logic [DIV_W-1:0] div_data;
    logic             div_ready, tick, clk_slow;
    logic [1:0]       state;
`ifdef TICK_COUNT_EN
    logic [15:0]      tick_count;
`endif

    countdown_tick_gen #(.DIV_W(DIV_W), .DEFAULT_DIV(DEF)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .clear     (clear),
        .div_valid (div_valid),
        .div_data  (div_data),
        .div_ready (div_ready),
        .tick      (tick),
        .clk_slow  (clk_slow),
        .state     (state)
`ifdef TICK_COUNT_EN
        ,
        .tick_count(tick_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         chk_ready;
        bit         ready;
        bit         tick;
        bit         slow;
        logic [1:0] st;
        logic [15:0] tc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: counts running cycles up since the last period start
    // and fires when that count reaches the active half-period.
    bit m_init    = 0;
    int m_state   = 0;   // 0 idle, 1 run, 2 pause
    int m_active  = DEF;
    int m_elapsed = 0;
    bit m_pending = 0;
    int m_shadow  = 1;
    bit m_slow    = 0;
    bit m_tick    = 0;
    int m_tc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit en, input bit clr, input bit vld,
                              input int data, output exp_t e);
        bit rdy;
        rdy = !m_pending && !clr;
        e.chk_ready = m_init;
        e.ready     = rdy;
        if (!rst) begin
            m_state = 0; m_active = DEF; m_elapsed = 0; m_pending = 0;
            m_slow = 0; m_tick = 0; m_tc = 0;
            m_init = 1;
        end else if (clr) begin
            m_state = 0; m_elapsed = 0; m_pending = 0; m_slow = 0; m_tick = 0; m_tc = 0;
        end else begin
            m_tick = 0;
            case (m_state)
                0: begin
                    m_elapsed = 0;
                    if (m_pending) begin m_active = m_shadow; m_pending = 0; end
                    if (en) m_state = 1;
                end
                1: begin
                    m_elapsed++;
                    if (m_elapsed == m_active) begin
                        m_tick = 1; m_slow = !m_slow; m_elapsed = 0;
                        m_tc = (m_tc + 1) % 65536;
                        if (m_pending) begin m_active = m_shadow; m_pending = 0; end
                    end
                    if (!en) m_state = 2;
                end
                default: if (en) m_state = 1;
            endcase
            if (vld && rdy) begin
                m_shadow  = (data == 0) ? 1 : data;
                m_pending = 1;
            end
        end
        e.tick = m_tick;
        e.slow = m_slow;
        e.st   = 2'(m_state);
        e.tc   = 16'(m_tc);
    endtask

    task automatic step(input bit rst, input bit en, input bit clr, input bit vld, input int data);
        exp_t e;
        @(negedge clk);
        reset_n   = rst;
        enable    = en;
        clear     = clr;
        div_valid = vld;
        div_data  = DIV_W'(data);
        model_edge(rst, en, clr, vld, data, e);
        exp_q.push_back(e);
    endtask

    // Run until the model is in RUN with the given elapsed count (bounded).
    task automatic run_until_elapsed(input int target);
        for (int i = 0; i < 64; i++) begin
            if (m_state == 1 && m_elapsed == target) break;
            step(1, 1, 0, 0, 0);
        end
    endtask

    // Monitor: div_ready is combinational on the inputs, so it is sampled
    // after the drive and before the edge; registered outputs after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_ready) chk("div_ready", 32'(div_ready), 32'(e.ready));
                @(posedge clk);
                #1;
                chk("tick", 32'(tick), 32'(e.tick));
                chk("clk_slow", 32'(clk_slow), 32'(e.slow));
                chk("state", 32'(state), 32'(e.st));
`ifdef TICK_COUNT_EN
                chk("tick_count", 32'(tick_count), 32'(e.tc));
`endif
            end
        end
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0; clear = 1'b0; div_valid = 1'b0; div_data = '0;

        // reset and idle
        repeat (3)  step(0, 0, 0, 0, 0);
        repeat (10) step(1, 0, 0, 0, 0);
        // run with default half-period
        repeat (34) step(1, 1, 0, 0, 0);
        // pause two running cycles after a tick, then resume
        run_until_elapsed(2);
        repeat (5)  step(1, 0, 0, 0, 0);
        repeat (12) step(1, 1, 0, 0, 0);
        // runtime load mid-period
        run_until_elapsed(1);
        step(1, 1, 0, 1, 6);
        repeat (3)  step(1, 1, 0, 1, 9);   // offered while not ready: must be ignored
        repeat (30) step(1, 1, 0, 0, 0);
        // clear on the same edge as a terminal count and a divisor offer
        run_until_elapsed(m_active - 1);
        step(1, 1, 1, 1, 3);
        repeat (3)  step(1, 0, 0, 0, 0);
        // load zero in idle -> half-period of one
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        repeat (12) step(1, 1, 0, 0, 0);
        // back to a pending divisor that a clear then discards
        step(1, 1, 0, 1, 5);
        step(1, 1, 1, 0, 0);
        repeat (8)  step(1, 1, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 12)));
        end

        // drain the scoreboard (bounded)
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 (entries left)", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_tick_gen.md
Name: countdown_tick_gen

Overview:
Programmable clock-enable generator that sits directly upstream of the LED blink stage and produces the slow blink timing it consumes. It divides the 100 MHz board clock by a runtime-loadable half-period and emits a one-cycle tick plus a registered 50%-duty square wave (clk_slow). It supports run, pause and clear control, and a valid/ready handshake for loading a new divisor glitch-free.

Parameters:
DIV_W, 27, width of divisor and down-counter.
DEFAULT_DIV, 50_000_000, half-period in clk cycles after reset (1 Hz blink at 100 MHz).

Ports:
clk  input  1  system clock, all logic on rising edge.
reset_n  input  1  synchronous reset, active-low.
enable  input  1  level; 1 = count, 0 = pause/hold.
clear  input  1  synchronous restart pulse.
div_valid  input  1  new divisor offered.
div_data  input  DIV_W  new half-period in cycles.
div_ready  output  1  divisor can be accepted.
tick  output  1  one-cycle pulse per half-period.
clk_slow  output  1  registered square wave; toggles with each tick.
state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset_n=0 at an edge) sets:
  - state=IDLE, active_div=DEFAULT_DIV, cnt=DEFAULT_DIV-1.
  - tick=0, clk_slow=0, pending=0, div_ready=1.
- FSM:
  - IDLE: cnt held at active_div-1. enable=1 -> RUN.
  - RUN: cnt decrements each cycle. enable=0 -> PAUSE.
  - PAUSE: cnt and clk_slow frozen, tick=0. enable=1 -> RUN, resuming from the frozen cnt.
- Terminal count: in a RUN cycle where cnt==0:
  - Next edge: tick=1 for exactly one cycle, clk_slow inverts, cnt reloads to active_div-1.
  - If pending=1 at that edge, active_div<=shadow, reload uses shadow-1, and pending clears.
- Timing: tick period is active_div cycles. The first tick is registered active_div edges after the edge that entered RUN. clk_slow period is 2*active_div.
- tick is registered and is 0 in every cycle not following a terminal count.
- Handshake:
  - div_ready = ~pending & ~clear.
  - Transfer when div_valid & div_ready at an edge: shadow<=div_data, pending<=1.
  - div_data==0 is stored as 1. Value 1 gives a tick every cycle and clk_slow = clk/2.
  - If state==IDLE, the pending value is applied on the next edge: active_div and cnt load, pending clears, no tick.
  - Only one pending value is held. div_ready stays 0 until it is applied.
- Clear (clear=1 at an edge):
  - state=IDLE, cnt=active_div-1, clk_slow=0, tick=0.
  - Pending shadow is discarded; active_div is kept.
  - Clear overrides enable and terminal count in the same cycle.
- Priority: reset_n > clear > terminal count/handshake > enable transitions.
- Entering PAUSE on the same edge as a terminal count: the tick and reload still happen, then the counter freezes.
- No arithmetic overflow: cnt never decrements below 0. Reload is always >=0 because active_div>=1.

Optional Feature:
TICK_COUNT_EN
- Defined: adds output tick_count [15:0], which increments on every registered tick and wraps 0xFFFF->0x0000. It resets to 0 on reset_n=0 or clear=1.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset/idle (DEFAULT_DIV=4): hold reset_n=0 for 3 cycles, release, enable=0 for 10 cycles -> tick=0, clk_slow=0, state=00, div_ready=1 throughout.
- Run period (DEFAULT_DIV=4): enable=1 -> state=01; tick pulses every 4 cycles starting 4 edges after RUN entry; clk_slow high 4, low 4; 8 ticks in 32 cycles.
- Pause/resume: pause 2 cycles after a tick for 5 cycles -> tick stays 0 and clk_slow is frozen. Next tick comes 2 running cycles after resume (total 4 running cycles).
- Runtime load: during RUN with div=4, load div_data=6 mid-period -> div_ready drops to 0. Current period still ends at 4 cycles; following ticks are 6 apart; div_ready returns to 1 on the reload edge. In IDLE, load 0 -> active_div=1 and a tick every cycle once enabled.
- Clear collision: assert clear on the same edge as a terminal count and a div_valid -> no tick, clk_slow=0, state=00, pending discarded, div_ready=0 during clear.
- TICK_COUNT_EN: run 65537 ticks with div=1 -> tick_count wraps to 0x0001. Clear -> 0x0000.
